// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the 8-bit-address shared bus.
// FSM encoding, address map, default response timeout and the
// select-priority helper used by the response collector.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } bus_state_t;

   localparam int unsigned NUM_SLV     = 4;
   localparam int unsigned TIMEOUT_DEF = 15;

   // Address map, inclusive ranges; every other address is unmapped
   localparam logic [7:0] S0_BASE = 8'h00;
   localparam logic [7:0] S0_LAST = 8'h0F;
   localparam logic [7:0] S1_BASE = 8'h10;
   localparam logic [7:0] S1_LAST = 8'h1F;
   localparam logic [7:0] S2_BASE = 8'h20;
   localparam logic [7:0] S2_LAST = 8'h3F;
   localparam logic [7:0] S3_BASE = 8'h40;
   localparam logic [7:0] S3_LAST = 8'h5F;

   // Keep only the highest-priority select bit: S0 > S1 > S2 > S3
   function automatic logic [NUM_SLV-1:0] prio_sel(input logic [NUM_SLV-1:0] sel);
      logic [NUM_SLV-1:0] res;
      logic               found;
      res   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_SLV; i++) begin
         if (sel[i] && !found) begin
            res[i] = 1'b1;
            found  = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bus_rdata_sel.sv
// bus_rdata_sel: combinational one-hot 4:1 mux returning the ready flag
// and read data of the slave picked by the latched select vector.
module bus_rdata_sel
   import bus_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [NUM_SLV-1:0]             sel,
   input  logic [NUM_SLV-1:0]             slv_ready,
   input  logic [NUM_SLV-1:0][DATA_W-1:0] slv_dout,
   output logic                           ready,
   output logic [DATA_W-1:0]              dout
);

   // AND-OR mux: sel is one-hot, so at most one slave contributes
   always_comb begin
      ready = 1'b0;
      dout  = '0;
      for (int unsigned i = 0; i < NUM_SLV; i++) begin
         ready = ready | (sel[i] & slv_ready[i]);
         dout  = dout | (slv_dout[i] & {DATA_W{sel[i]}});
      end
   end

endmodule

// File: rtl/bus_resp.sv
// bus_resp: master-side response collector for the shared bus.
// Latches the slave select on a master request, waits for that slave's
// ready, and returns its read data with a one-cycle M_rvalid pulse.
// Unmapped requests answer with M_err. Optional macro
// BUS_RESP_TIMEOUT_EN adds a WAIT-cycle counter that answers with an
// error after TIMEOUT cycles without ready.
module bus_resp
   import bus_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              M_req,
   input  logic              M_wr,
   input  logic              S0_sel,
   input  logic              S1_sel,
   input  logic              S2_sel,
   input  logic              S3_sel,
   input  logic              S0_ready,
   input  logic              S1_ready,
   input  logic              S2_ready,
   input  logic              S3_ready,
   input  logic [DATA_W-1:0] S0_dout,
   input  logic [DATA_W-1:0] S1_dout,
   input  logic [DATA_W-1:0] S2_dout,
   input  logic [DATA_W-1:0] S3_dout,
   output logic [DATA_W-1:0] M_dout,
   output logic              M_rvalid,
   output logic              M_err,
   output logic              M_busy
);

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("bus_resp: TIMEOUT must be in 1..255");
   end

   bus_state_t         state_q, state_d;
   logic [NUM_SLV-1:0] sel_q, sel_d;
   logic               wr_q, wr_d;
   logic               err_q, err_d;
   logic [DATA_W-1:0]  dout_q, dout_d;
   logic               rvalid_q, rvalid_d;
   logic               merr_q, merr_d;

   logic [NUM_SLV-1:0] sel_in;
   logic               slv_ready;
   logic [DATA_W-1:0]  slv_dout;

`ifdef BUS_RESP_TIMEOUT_EN
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
   logic [7:0] cnt_q, cnt_d;
`endif

   assign sel_in = {S3_sel, S2_sel, S1_sel, S0_sel};

   bus_rdata_sel #(
      .DATA_W (DATA_W)
   ) u_rdata_sel (
      .sel       (sel_q),
      .slv_ready ({S3_ready, S2_ready, S1_ready, S0_ready}),
      .slv_dout  ({S3_dout, S2_dout, S1_dout, S0_dout}),
      .ready     (slv_ready),
      .dout      (slv_dout)
   );

   // Next-state and next registered-output values; rvalid/err default low
   // so the response pulse lasts exactly the RESP cycle
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      wr_d     = wr_q;
      err_d    = err_q;
      dout_d   = dout_q;
      rvalid_d = 1'b0;
      merr_d   = 1'b0;
`ifdef BUS_RESP_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (M_req) begin
               sel_d = prio_sel(sel_in);
               wr_d  = M_wr;
               if (sel_in == '0) begin
                  err_d    = 1'b1;
                  dout_d   = '0;
                  rvalid_d = 1'b1;
                  merr_d   = 1'b1;
                  state_d  = RESP;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            // Ready is checked before the timeout so it wins on the last cycle
            if (slv_ready) begin
               dout_d   = wr_q ? '0 : slv_dout;
               rvalid_d = 1'b1;
               merr_d   = err_q;
               state_d  = RESP;
            end
`ifdef BUS_RESP_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               cnt_d    = cnt_q + 8'd1;
               err_d    = 1'b1;
               dout_d   = '0;
               rvalid_d = 1'b1;
               merr_d   = 1'b1;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         RESP: begin
            err_d   = 1'b0;
`ifdef BUS_RESP_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset aborts any transaction in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         wr_q     <= 1'b0;
         err_q    <= 1'b0;
         dout_q   <= '0;
         rvalid_q <= 1'b0;
         merr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         wr_q     <= wr_d;
         err_q    <= err_d;
         dout_q   <= dout_d;
         rvalid_q <= rvalid_d;
         merr_q   <= merr_d;
      end
   end

`ifdef BUS_RESP_TIMEOUT_EN
   // WAIT-cycle counter, cleared on reset and on the exit from RESP
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign M_dout   = dout_q;
   assign M_rvalid = rvalid_q;
   assign M_err    = merr_q;
   assign M_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_bus_resp.sv
// tb_bus_resp: directed bench for bus_resp. A transaction-level model
// predicts, per request, the edge of the response and its data/error;
// a negedge process checks all outputs against it every cycle.
module tb_bus_resp;

   localparam int unsigned DW  = 32;
   localparam int          TO  = 15;
   localparam int          INF = 1000000;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          M_req, M_wr;
   logic [3:0]    sel_bus, rdy_bus;
   logic [DW-1:0] dout_v [4];
   logic [DW-1:0] M_dout;
   logic          M_rvalid, M_err, M_busy;

   int            cyc = 0;
   int            rdy_edge [4];
   int            busy_from, resp_at;
   logic          resp_err;
   logic [DW-1:0] resp_dout, exp_dout;
   int            n_cmp = 0;
   int            n_bad = 0;

   bus_resp #(
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .M_req    (M_req),
      .M_wr     (M_wr),
      .S0_sel   (sel_bus[0]),
      .S1_sel   (sel_bus[1]),
      .S2_sel   (sel_bus[2]),
      .S3_sel   (sel_bus[3]),
      .S0_ready (rdy_bus[0]),
      .S1_ready (rdy_bus[1]),
      .S2_ready (rdy_bus[2]),
      .S3_ready (rdy_bus[3]),
      .S0_dout  (dout_v[0]),
      .S1_dout  (dout_v[1]),
      .S2_dout  (dout_v[2]),
      .S3_dout  (dout_v[3]),
      .M_dout   (M_dout),
      .M_rvalid (M_rvalid),
      .M_err    (M_err),
      .M_busy   (M_busy)
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges seen so far
   always @(posedge clk) cyc <= cyc + 1;

   // Slave i is ready when sampled at edges >= rdy_edge[i] (-1: never)
   always @(posedge clk) begin
      #3;
      for (int i = 0; i < 4; i++)
         rdy_bus[i] = (rdy_edge[i] >= 0) && (cyc + 1 >= rdy_edge[i]);
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Per-cycle compare against the transaction model
   always @(negedge clk) begin
      logic e_rv, e_busy, e_err;
      e_rv   = reset_n && (cyc == resp_at);
      e_busy = reset_n && (busy_from >= 0) && (cyc >= busy_from) && (cyc <= resp_at);
      e_err  = e_rv && resp_err;
      if (e_rv) exp_dout = resp_dout;
      chk("rvalid", M_rvalid, e_rv);
      chk("err",    M_err,    e_err);
      chk("busy",   M_busy,   e_busy);
      chk("dout",   M_dout,   exp_dout);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic goto_cycle(input int c);
      int k = 0;
      while (cyc < c && k < 1000) begin
         step(1);
         k++;
      end
      if (cyc < c) begin
         n_cmp++;
         n_bad++;
         $display("FAIL goto budget: at cycle %0d, required %0d", cyc, c);
      end
   endtask

   task automatic wait_done();
      int k = 0;
      while (cyc <= resp_at && k < 200) begin
         step(1);
         k++;
      end
      if (cyc <= resp_at) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait budget: at cycle %0d, response due %0d", cyc, resp_at);
      end
   endtask

   function automatic int winner(input logic [3:0] s);
      if (s[0]) return 0;
      if (s[1]) return 1;
      if (s[2]) return 2;
      if (s[3]) return 3;
      return -1;
   endfunction

   // Issue one request; dly = edges after the sampling edge at which the
   // winning slave turns ready (<0: never). Predicts the response.
   task automatic txn(input logic [3:0] sel, input logic wr, input int dly, output int n);
      int w, r;
      n = cyc + 1;
      w = winner(sel);
      busy_from = n;
      if (w < 0) begin
         resp_at   = n;
         resp_err  = 1'b1;
         resp_dout = '0;
      end else begin
         if (dly < 0) begin
            rdy_edge[w] = -1;
            r = INF;
         end else begin
            rdy_edge[w] = n + dly;
            r = (dly < 1) ? n + 1 : n + dly;
         end
         resp_at   = r;
         resp_err  = 1'b0;
         resp_dout = wr ? '0 : dout_v[w];
`ifdef BUS_RESP_TIMEOUT_EN
         if (r > n + TO) begin
            resp_at   = n + TO;
            resp_err  = 1'b1;
            resp_dout = '0;
         end
`endif
      end
      M_req   = 1'b1;
      M_wr    = wr;
      sel_bus = sel;
      step(1);
      M_req   = 1'b0;
      M_wr    = 1'b0;
      sel_bus = '0;
   endtask

   task automatic pulse_reset(input int len);
      reset_n   = 1'b0;
      busy_from = -1;
      resp_at   = -1;
      exp_dout  = '0;
      step(len);
      reset_n   = 1'b1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int n;
      reset_n = 1'b0;
      M_req   = 1'b0;
      M_wr    = 1'b0;
      sel_bus = '0;
      rdy_bus = '0;
      for (int i = 0; i < 4; i++) begin
         rdy_edge[i] = -1;
         dout_v[i]   = '0;
      end
      busy_from = -1;
      resp_at   = -1;
      resp_err  = 1'b0;
      resp_dout = '0;
      exp_dout  = '0;

      // Reset and idle
      step(3);
      reset_n = 1'b1;
      step(10);
      chk("idle_busy",   M_busy,   0);
      chk("idle_rvalid", M_rvalid, 0);
      chk("idle_dout",   M_dout,   0);

      // Read from slave 1, already ready: response 2 edges after request
      dout_v[1] = 32'hA5A5_0001;
      txn(4'b0010, 1'b0, 0, n);
      chk("rd1_early_rvalid", M_rvalid, 0);
      step(1);
      chk("rd1_rvalid", M_rvalid, 1);
      chk("rd1_dout",   M_dout,   32'hA5A5_0001);
      chk("rd1_err",    M_err,    0);
      wait_done();

      // Unmapped address: error after one edge, busy exactly one cycle
      txn(4'b0000, 1'b0, 0, n);
      chk("unm_rvalid", M_rvalid, 1);
      chk("unm_err",    M_err,    1);
      chk("unm_busy",   M_busy,   1);
      chk("unm_dout",   M_dout,   0);
      step(1);
      chk("unm_busy_end",   M_busy,   0);
      chk("unm_rvalid_end", M_rvalid, 0);

      // Slave 3 with 5 wait edges, slave 2 ready throughout, stray request
      dout_v[2]   = 32'h2222_0002;
      dout_v[3]   = 32'h3C3C_0003;
      rdy_edge[2] = 0;
      txn(4'b1000, 1'b0, 5, n);
      step(1);
      M_req = 1'b1;
      step(1);
      M_req = 1'b0;
      goto_cycle(n + 4);
      chk("s3_wait_rvalid", M_rvalid, 0);
      chk("s3_wait_busy",   M_busy,   1);
      step(1);
      chk("s3_rvalid", M_rvalid, 1);
      chk("s3_dout",   M_dout,   32'h3C3C_0003);
      wait_done();

      // Priority: S2 beats S3 (S3 already ready); all four -> S0
      txn(4'b1100, 1'b0, 2, n);
      goto_cycle(n + 2);
      chk("pri23_rvalid", M_rvalid, 1);
      chk("pri23_dout",   M_dout,   32'h2222_0002);
      wait_done();
      dout_v[0] = 32'h0000_00F0;
      txn(4'b1111, 1'b0, 1, n);
      step(1);
      chk("pri_all_dout", M_dout, 32'h0000_00F0);
      wait_done();

      // Write response returns zero data
      txn(4'b0100, 1'b1, 1, n);
      step(1);
      chk("wr_rvalid", M_rvalid, 1);
      chk("wr_dout",   M_dout,   0);
      chk("wr_err",    M_err,    0);
      wait_done();

      // Back-to-back transactions at the first IDLE edge
      txn(4'b0010, 1'b0, 0, n);
      wait_done();
      txn(4'b0100, 1'b0, 2, n);
      wait_done();
      txn(4'b0001, 1'b0, 0, n);
      wait_done();

`ifdef BUS_RESP_TIMEOUT_EN
      // Slave 0 never ready: error after 15 WAIT cycles
      txn(4'b0001, 1'b0, -1, n);
      goto_cycle(n + 14);
      chk("to_early_rvalid", M_rvalid, 0);
      chk("to_early_busy",   M_busy,   1);
      step(1);
      chk("to_rvalid", M_rvalid, 1);
      chk("to_err",    M_err,    1);
      chk("to_dout",   M_dout,   0);
      wait_done();
      // Ready on the very edge the count expires wins
      dout_v[0] = 32'h5A5A_0F0F;
      txn(4'b0001, 1'b0, TO, n);
      goto_cycle(n + TO);
      chk("to_edge_rvalid", M_rvalid, 1);
      chk("to_edge_err",    M_err,    0);
      chk("to_edge_dout",   M_dout,   32'h5A5A_0F0F);
      wait_done();
`else
      // Without the timeout a stalled slave keeps the block busy
      txn(4'b0001, 1'b0, -1, n);
      goto_cycle(n + 100);
      chk("hang_busy",   M_busy,   1);
      chk("hang_rvalid", M_rvalid, 0);
      pulse_reset(2);
      step(2);
`endif

      // Reset during WAIT aborts; the next request completes normally
      txn(4'b0001, 1'b0, 8, n);
      step(3);
      pulse_reset(1);
      step(2);
      chk("rst_busy", M_busy, 0);
      chk("rst_dout", M_dout, 0);
      txn(4'b0100, 1'b0, 0, n);
      step(1);
      chk("post_rst_rvalid", M_rvalid, 1);
      chk("post_rst_dout",   M_dout,   32'h2222_0002);
      wait_done();
      step(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
